// File: rtl/ri5cy_mem_pkg.sv
// Shared types and helpers for the RI5CY data-memory responder.
package ri5cy_mem_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int BE_WIDTH   = DATA_WIDTH / 8;

    // One slot of the response pipeline.
    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] rdata;
    } mem_resp_t;

    // Merge new bytes into an old word under byte enables; disabled bytes keep old data.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [BE_WIDTH-1:0]   be
    );
        logic [DATA_WIDTH-1:0] result;
        result = old_word;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (be[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                result[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// Fixed-latency in-order response pipeline; reset flushes every in-flight slot.
module mem_resp_pipe
    import ri5cy_mem_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_rdata_i,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_rdata_o
);

    mem_resp_t stage_q [LATENCY];
    mem_resp_t stage_d [LATENCY];

    // Shift every slot one place down the pipe, new response enters slot 0.
    always_comb begin
        stage_d[0].valid = in_valid_i;
        stage_d[0].rdata = in_rdata_i;
        for (int i = 1; i < LATENCY; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Pipeline registers, cleared on reset so no response survives it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign out_valid_o = stage_q[LATENCY-1].valid;
    assign out_rdata_o = stage_q[LATENCY-1].rdata;

endmodule

// File: rtl/ri5cy_data_mem_responder.sv
// Data-memory responder: word RAM, grant throttling, fixed-latency responses, statistics.
module ri5cy_data_mem_responder #(
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 32,
    parameter int MEM_WORDS       = 4096,
    parameter int LATENCY         = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STALL_PERIOD    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    data_req_i,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,
    output logic [31:0]             req_count_o,
    output logic [31:0]             write_count_o
);

    import ri5cy_mem_pkg::*;

    localparam int          IDX_W      = $clog2(MEM_WORDS);
    localparam logic        STALL_EN   = (STALL_PERIOD != 0);
    localparam logic [31:0] STALL_LAST = (STALL_PERIOD == 0) ? 32'd0 : 32'(STALL_PERIOD - 1);
    localparam logic [3:0]  MAX_OUT    = 4'(MAX_OUTSTANDING);
    // Grant right after reset: counters are zero, so only a period of 1 stalls.
    localparam logic        GNT_RST    = (STALL_PERIOD != 1);

    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

    logic [IDX_W-1:0]      word_idx_s;
    logic                  accept_s;
    logic                  push_valid_s;
    logic [DATA_WIDTH-1:0] push_rdata_s;
    logic                  rvalid_s;
    logic [DATA_WIDTH-1:0] rdata_s;
    logic                  unused_s;

    logic [3:0]  outstanding_q, outstanding_d;
    logic [31:0] stall_cnt_q,   stall_cnt_d;
    logic        gnt_q,         gnt_d;
    logic [31:0] req_count_q,   req_count_d;
    logic [31:0] write_count_q, write_count_d;

    // Out-of-range addresses alias onto the RAM; byte-offset bits carry no meaning.
    assign word_idx_s = data_addr_i[IDX_W+1:2];
    assign unused_s   = ^data_addr_i;
    assign accept_s   = data_req_i && gnt_q;

    // Response payload: old RAM word for reads, zero for writes and idle cycles.
    always_comb begin
        push_valid_s = accept_s;
        if (accept_s && !data_we_i) begin
            push_rdata_s = mem_q[word_idx_s];
        end else begin
            push_rdata_s = '0;
        end
    end

    // Byte-masked RAM write; never reset, and a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (accept_s && data_we_i && !rst) begin
            mem_q[word_idx_s] <= merge_bytes(mem_q[word_idx_s], data_wdata_i, data_be_i);
        end
    end

    // Next-state for occupancy, stall phase, grant and statistics.
    always_comb begin
        outstanding_d = outstanding_q;
        stall_cnt_d   = stall_cnt_q;
        gnt_d         = gnt_q;
        req_count_d   = req_count_q;
        write_count_d = write_count_q;

        if (accept_s && !rvalid_s) begin
            outstanding_d = outstanding_q + 4'd1;
        end else if (!accept_s && rvalid_s) begin
            outstanding_d = outstanding_q - 4'd1;
        end else begin
            outstanding_d = outstanding_q;
        end

        if (!STALL_EN) begin
            stall_cnt_d = 32'd0;
        end else if (stall_cnt_q == STALL_LAST) begin
            stall_cnt_d = 32'd0;
        end else begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end

        // Grant is registered from next state, so it depends only on registered state.
        gnt_d = !(STALL_EN && (stall_cnt_d == STALL_LAST)) && (outstanding_d < MAX_OUT);

        req_count_d   = req_count_q + {31'd0, accept_s};
        write_count_d = write_count_q + {31'd0, accept_s && data_we_i};
    end

    // Control and statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_q <= 4'd0;
            stall_cnt_q   <= 32'd0;
            gnt_q         <= GNT_RST;
            req_count_q   <= 32'd0;
            write_count_q <= 32'd0;
        end else begin
            outstanding_q <= outstanding_d;
            stall_cnt_q   <= stall_cnt_d;
            gnt_q         <= gnt_d;
            req_count_q   <= req_count_d;
            write_count_q <= write_count_d;
        end
    end

    mem_resp_pipe #(
        .LATENCY (LATENCY)
    ) u_resp_pipe (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (push_valid_s),
        .in_rdata_i  (push_rdata_s),
        .out_valid_o (rvalid_s),
        .out_rdata_o (rdata_s)
    );

    assign data_gnt_o    = gnt_q;
    assign data_rvalid_o = rvalid_s;
    assign data_rdata_o  = rdata_s;
    assign req_count_o   = req_count_q;
    assign write_count_o = write_count_q;

endmodule

// File: tb/tb_ri5cy_data_mem_responder.sv
// Directed bench: default config (a_*), LATENCY=3/MAX_OUTSTANDING=2 (b_*), STALL_PERIOD=4 (c_*).
module tb_ri5cy_data_mem_responder;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    logic        a_req, a_we, a_gnt, a_rvalid;
    logic [15:0] a_addr;
    logic [3:0]  a_be;
    logic [31:0] a_wdata, a_rdata, a_reqc, a_wrc;

    logic        b_req, b_we, b_gnt, b_rvalid;
    logic [15:0] b_addr;
    logic [3:0]  b_be;
    logic [31:0] b_wdata, b_rdata, b_reqc, b_wrc;

    logic        c_req, c_we, c_gnt, c_rvalid;
    logic [15:0] c_addr;
    logic [3:0]  c_be;
    logic [31:0] c_wdata, c_rdata, c_reqc, c_wrc;

    always #5 clk = ~clk;

    ri5cy_data_mem_responder u_a (
        .clk(clk), .rst(rst), .data_req_i(a_req), .data_addr_i(a_addr), .data_we_i(a_we),
        .data_be_i(a_be), .data_wdata_i(a_wdata), .data_gnt_o(a_gnt), .data_rvalid_o(a_rvalid),
        .data_rdata_o(a_rdata), .req_count_o(a_reqc), .write_count_o(a_wrc)
    );

    ri5cy_data_mem_responder #(.LATENCY(3), .MAX_OUTSTANDING(2)) u_b (
        .clk(clk), .rst(rst), .data_req_i(b_req), .data_addr_i(b_addr), .data_we_i(b_we),
        .data_be_i(b_be), .data_wdata_i(b_wdata), .data_gnt_o(b_gnt), .data_rvalid_o(b_rvalid),
        .data_rdata_o(b_rdata), .req_count_o(b_reqc), .write_count_o(b_wrc)
    );

    ri5cy_data_mem_responder #(.STALL_PERIOD(4)) u_c (
        .clk(clk), .rst(rst), .data_req_i(c_req), .data_addr_i(c_addr), .data_we_i(c_we),
        .data_be_i(c_be), .data_wdata_i(c_wdata), .data_gnt_o(c_gnt), .data_rvalid_o(c_rvalid),
        .data_rdata_o(c_rdata), .req_count_o(c_reqc), .write_count_o(c_wrc)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Reset all three instances; returns in the first cycle after reset.
    task automatic do_reset;
        rst   = 1'b1;
        a_req = 1'b0;
        b_req = 1'b0;
        c_req = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // Present one request on instance a and hold it until granted and accepted.
    task automatic a_issue(input logic we, input logic [15:0] addr, input logic [3:0] be,
                           input logic [31:0] wd);
        int n;
        n       = 0;
        a_req   = 1'b1;
        a_we    = we;
        a_addr  = addr;
        a_be    = be;
        a_wdata = wd;
        while (!a_gnt && n < 20) begin
            step();
            n++;
        end
        total++;
        if (a_gnt !== 1'b1) begin
            bad++;
            $display("FAIL a_issue_gnt got=%b want=1", a_gnt);
        end
        step();
        a_req = 1'b0;
    endtask

    // Wait (bounded) for the next response on instance a and return its data.
    task automatic a_wait_resp(output logic [31:0] d);
        int n;
        n = 0;
        while (!a_rvalid && n < 20) begin
            step();
            n++;
        end
        total++;
        if (a_rvalid !== 1'b1) begin
            bad++;
            $display("FAIL a_resp_timeout got rvalid=%b want=1", a_rvalid);
            d = 32'h0;
        end else begin
            d = a_rdata;
            step();
        end
    endtask

    task automatic test_reset;
        do_reset();
        total += 7;
        if (a_gnt !== 1'b1)      begin bad++; $display("FAIL rst_a_gnt got=%b want=1", a_gnt); end
        if (a_rvalid !== 1'b0)   begin bad++; $display("FAIL rst_rvalid got=%b want=0", a_rvalid); end
        if (a_rdata !== 32'h0)   begin bad++; $display("FAIL rst_rdata got=%h want=0", a_rdata); end
        if (a_reqc !== 32'd0)    begin bad++; $display("FAIL rst_reqc got=%0d want=0", a_reqc); end
        if (a_wrc !== 32'd0)     begin bad++; $display("FAIL rst_wrc got=%0d want=0", a_wrc); end
        if (b_gnt !== 1'b1)      begin bad++; $display("FAIL rst_b_gnt got=%b want=1", b_gnt); end
        if (c_gnt !== 1'b1)      begin bad++; $display("FAIL rst_c_gnt got=%b want=1", c_gnt); end
    endtask

    task automatic test_write_read;
        do_reset();
        a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0040; a_be = 4'hF; a_wdata = 32'hDEADBEEF;
        total++;
        if (a_gnt !== 1'b1) begin bad++; $display("FAIL wr_gnt got=%b want=1", a_gnt); end
        step();
        a_we = 1'b0; a_wdata = 32'h0;
        total += 2;
        if (a_rvalid !== 1'b0) begin bad++; $display("FAIL wr_early_rvalid got=%b want=0", a_rvalid); end
        if (a_gnt !== 1'b1)    begin bad++; $display("FAIL rd_gnt got=%b want=1", a_gnt); end
        step();
        a_req = 1'b0;
        total += 2;
        if (a_rvalid !== 1'b1)  begin bad++; $display("FAIL wr_rvalid got=%b want=1", a_rvalid); end
        if (a_rdata !== 32'h0)  begin bad++; $display("FAIL wr_rdata got=%h want=0", a_rdata); end
        step();
        total += 4;
        if (a_rvalid !== 1'b1)         begin bad++; $display("FAIL rd_rvalid got=%b want=1", a_rvalid); end
        if (a_rdata !== 32'hDEADBEEF)  begin bad++; $display("FAIL rd_rdata got=%h want=deadbeef", a_rdata); end
        if (a_reqc !== 32'd2)          begin bad++; $display("FAIL wr_rd_reqc got=%0d want=2", a_reqc); end
        if (a_wrc !== 32'd1)           begin bad++; $display("FAIL wr_rd_wrc got=%0d want=1", a_wrc); end
        step();
        total++;
        if (a_rvalid !== 1'b0) begin bad++; $display("FAIL rd_extra_rvalid got=%b want=0", a_rvalid); end
    endtask

    task automatic test_byte_enable;
        logic [31:0] d;
        a_issue(1'b1, 16'h0010, 4'hF, 32'h11223344);
        a_wait_resp(d);
        a_issue(1'b1, 16'h0010, 4'h5, 32'hAABBCCDD);
        a_wait_resp(d);
        a_issue(1'b0, 16'h0010, 4'h0, 32'h0);
        a_wait_resp(d);
        total++;
        if (d !== 32'h11BB33DD) begin bad++; $display("FAIL be_merge got=%h want=11bb33dd", d); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_q [$];
        logic [31:0] want;
        logic [7:0]  pat;
        int acc, rsp, cyc, inflight, maxin;
        pat = 8'h33;  // expected gnt c0..c7 LSB first: 1,1,0,0,1,1,0,0
        do_reset();
        for (int ph = 0; ph < 2; ph++) begin
            acc = 0; rsp = 0; cyc = 0; inflight = 0; maxin = 0;
            b_we = (ph == 0);
            b_be = 4'hF;
            while ((acc < 6 || rsp < 6) && cyc < 60) begin
                if (b_rvalid) begin
                    want = 32'h0;
                    if (ph == 1) begin
                        if (exp_q.size() > 0) want = exp_q.pop_front();
                        else want = 32'hFFFFFFFF;
                    end
                    total++;
                    if (b_rdata !== want) begin
                        bad++;
                        $display("FAIL b2b_rdata ph=%0d rsp=%0d got=%h want=%h", ph, rsp, b_rdata, want);
                    end
                    rsp++;
                    inflight--;
                end
                if (ph == 1 && cyc < 8) begin
                    total++;
                    if (b_gnt !== pat[cyc]) begin
                        bad++;
                        $display("FAIL b2b_gnt cyc=%0d got=%b want=%b", cyc, b_gnt, pat[cyc]);
                    end
                end
                if (acc < 6) begin
                    b_req   = 1'b1;
                    b_addr  = 16'(acc * 4);
                    b_wdata = 32'hC0DE0000 + 32'(acc);
                end else begin
                    b_req = 1'b0;
                end
                if (b_req && b_gnt) begin
                    if (ph == 1) exp_q.push_back(32'hC0DE0000 + 32'(acc));
                    acc++;
                    inflight++;
                end
                if (inflight > maxin) maxin = inflight;
                step();
                cyc++;
            end
            b_req = 1'b0;
            total += 3;
            if (acc != 6 || rsp != 6) begin
                bad++; $display("FAIL b2b_done ph=%0d got acc=%0d rsp=%0d want 6/6", ph, acc, rsp);
            end
            if (maxin > 2) begin bad++; $display("FAIL b2b_outstanding got=%0d want<=2", maxin); end
            if (b_reqc !== 32'(6 * (ph + 1))) begin
                bad++; $display("FAIL b2b_reqc got=%0d want=%0d", b_reqc, 6 * (ph + 1));
            end
        end
    endtask

    task automatic test_stall;
        int acc, rsp;
        logic want;
        acc = 0; rsp = 0;
        do_reset();
        c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0; c_be = 4'hF; c_wdata = 32'h0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            want = ((cyc % 4) != 3);
            total++;
            if (c_gnt !== want) begin
                bad++; $display("FAIL stall_gnt cyc=%0d got=%b want=%b", cyc, c_gnt, want);
            end
            if (c_gnt) acc++;
            if (c_rvalid) rsp++;
            step();
        end
        c_req = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            if (c_rvalid) rsp++;
            step();
        end
        total += 3;
        if (acc != 9)                begin bad++; $display("FAIL stall_acc got=%0d want=9", acc); end
        if (c_reqc !== 32'(acc))     begin bad++; $display("FAIL stall_reqc got=%0d want=%0d", c_reqc, acc); end
        if (rsp != 9)                begin bad++; $display("FAIL stall_rsp got=%0d want=9", rsp); end
    endtask

    task automatic test_reset_midflight;
        logic [31:0] d;
        int seen;
        seen = 0;
        a_issue(1'b1, 16'h0080, 4'hF, 32'h12345678);
        a_wait_resp(d);
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0080; a_be = 4'hF; a_wdata = 32'h0;
        total++;
        if (a_gnt !== 1'b1) begin bad++; $display("FAIL mid_gnt got=%b want=1", a_gnt); end
        step();
        // Reset lands one cycle before the read's response, together with a write.
        rst = 1'b1; a_we = 1'b1; a_wdata = 32'hFFFFFFFF;
        step();
        rst = 1'b0; a_req = 1'b0;
        total += 3;
        if (a_reqc !== 32'd0) begin bad++; $display("FAIL mid_reqc got=%0d want=0", a_reqc); end
        if (a_wrc !== 32'd0)  begin bad++; $display("FAIL mid_wrc got=%0d want=0", a_wrc); end
        if (a_gnt !== 1'b1)   begin bad++; $display("FAIL mid_gnt_after got=%b want=1", a_gnt); end
        for (int i = 0; i < 5; i++) begin
            if (a_rvalid) seen++;
            step();
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL mid_rvalid got=%0d pulses want=0", seen); end
        a_issue(1'b0, 16'h0080, 4'hF, 32'h0);
        a_wait_resp(d);
        total++;
        if (d !== 32'h12345678) begin bad++; $display("FAIL mid_ram got=%h want=12345678", d); end
    endtask

    task automatic test_wrap;
        logic [31:0] d;
        a_issue(1'b1, 16'h4000, 4'hF, 32'h5A5A5A5A);
        a_wait_resp(d);
        a_issue(1'b0, 16'h0000, 4'hF, 32'h0);
        a_wait_resp(d);
        total++;
        if (d !== 32'h5A5A5A5A) begin bad++; $display("FAIL wrap_rdata got=%h want=5a5a5a5a", d); end
    endtask

    initial begin
        rst = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = 16'h0; a_be = 4'h0; a_wdata = 32'h0;
        b_req = 1'b0; b_we = 1'b0; b_addr = 16'h0; b_be = 4'h0; b_wdata = 32'h0;
        c_req = 1'b0; c_we = 1'b0; c_addr = 16'h0; c_be = 4'h0; c_wdata = 32'h0;
        test_reset();
        test_write_read();
        test_byte_enable();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
